inst_queue: RTL



---
 rtl/inst_queue_pkg.sv | 20 ++
 rtl/inst_queue_ram.sv | 38 +++
 rtl/inst_queue.sv | 129 ++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared constants, entry layout and small helpers for the fetch-to-decode
// instruction queue.
package inst_queue_pkg;

  localparam int RV32_INST_WIDTH = 32;
  localparam int INSTQ_DEPTH     = 8;
  localparam int INSTQ_PTR_W     = $clog2(INSTQ_DEPTH);
  localparam int INSTQ_CNT_W     = INSTQ_PTR_W + 1;
  localparam int INSTQ_ENTRY_W   = RV32_INST_WIDTH + 32;

  typedef struct packed {
    logic [RV32_INST_WIDTH-1:0] inst;
    logic [31:0]                pc;
  } instq_entry_t;

  function automatic logic [1:0] popcount2(input logic [1:0] mask);
    return {1'b0, mask[0]} + {1'b0, mask[1]};
  endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// DEPTH-entry flop array with two write ports and two asynchronous read
// ports. The queue guarantees the two write addresses never collide.
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = INSTQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [1:0]               i_we,
  input  logic [PTR_W-1:0]         i_waddr0,
  input  logic [PTR_W-1:0]         i_waddr1,
  input  logic [INSTQ_ENTRY_W-1:0] i_wdata0,
  input  logic [INSTQ_ENTRY_W-1:0] i_wdata1,
  input  logic [PTR_W-1:0]         i_raddr0,
  input  logic [PTR_W-1:0]         i_raddr1,
  output logic [INSTQ_ENTRY_W-1:0] o_rdata0,
  output logic [INSTQ_ENTRY_W-1:0] o_rdata1
);

  logic [INSTQ_ENTRY_W-1:0] mem [DEPTH];

  // NOTE: the array is reset on purpose so masked or stale entries read as
  // zero after reset; that costs a reset net on every storage flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (i_we[0]) mem[i_waddr0] <= i_wdata0;
      if (i_we[1]) mem[i_waddr1] <= i_wdata1;
    end
  end

  assign o_rdata0 = mem[i_raddr0];
  assign o_rdata1 = mem[i_raddr1];

endmodule

// File: rtl/inst_queue.sv
// Two-wide in-order instruction queue between fetch and decode. Pointer,
// occupancy and ready/valid logic live here; storage is inst_queue_ram.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = INSTQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic [1:0]       i_fetch_vld,
  input  logic [31:0]      i_fetch_inst0,
  input  logic [31:0]      i_fetch_inst1,
  input  logic [31:0]      i_fetch_pc0,
  input  logic [31:0]      i_fetch_pc1,
  output logic             o_fetch_rdy,
  output logic [1:0]       o_dec_vld,
  output logic [31:0]      o_dec_inst0,
  output logic [31:0]      o_dec_inst1,
  output logic [31:0]      o_dec_pc0,
  output logic [31:0]      o_dec_pc1,
  input  logic [1:0]       i_dec_take,
  output logic [CNT_W-1:0] o_count
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("inst_queue: DEPTH must be a power of two and at least 4");
  end

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             fetch_rdy;
  logic [1:0]       dec_vld;
  logic [1:0]       enq_we;
  logic [1:0]       deq_mask;
  logic [1:0]       n_enq;
  logic [1:0]       n_deq;

  logic [INSTQ_ENTRY_W-1:0] rdata0, rdata1;
  instq_entry_t             rd_entry0, rd_entry1;

  // Status comes from registered occupancy only, so a dequeue in the current
  // cycle cannot open the fetch gate until the next cycle.
  assign fetch_rdy = (count_q <= CNT_W'(DEPTH - 2));
  assign dec_vld   = {count_q >= CNT_W'(2), count_q != '0};

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value held and infer a latch.
  always_comb begin
    enq_we = 2'b00;
    if (fetch_rdy && !i_flush) begin
      unique case (i_fetch_vld)
        2'b01:   enq_we = 2'b01;
        2'b11:   enq_we = 2'b11;
        default: enq_we = 2'b00;
      endcase
    end
  end

  assign deq_mask = i_dec_take & dec_vld;
  assign n_enq    = popcount2(enq_we);
  assign n_deq    = popcount2(deq_mask);

  always_comb begin
    head_d  = head_q + PTR_W'(n_deq);
    tail_d  = tail_q + PTR_W'(n_enq);
    count_d = count_q + CNT_W'(n_enq) - CNT_W'(n_deq);
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Pointer arithmetic is modulo DEPTH by width, so slot1 wraps to entry 0
  // independently of slot0.
  inst_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (enq_we),
    .i_waddr0 (tail_q),
    .i_waddr1 (tail_q + PTR_W'(1)),
    .i_wdata0 ({i_fetch_inst0, i_fetch_pc0}),
    .i_wdata1 ({i_fetch_inst1, i_fetch_pc1}),
    .i_raddr0 (head_q),
    .i_raddr1 (head_q + PTR_W'(1)),
    .o_rdata0 (rdata0),
    .o_rdata1 (rdata1)
  );

  assign rd_entry0 = rdata0;
  assign rd_entry1 = rdata1;

  // Masked lanes drive zero, which decodes as illegal downstream.
  assign o_dec_inst0 = dec_vld[0] ? rd_entry0.inst : '0;
  assign o_dec_pc0   = dec_vld[0] ? rd_entry0.pc   : '0;
  assign o_dec_inst1 = dec_vld[1] ? rd_entry1.inst : '0;
  assign o_dec_pc1   = dec_vld[1] ? rd_entry1.pc   : '0;

  assign o_fetch_rdy = fetch_rdy;
  assign o_dec_vld   = dec_vld;
  assign o_count     = count_q;

  fetch_vld_legal: assert property (
    @(posedge i_clk) disable iff (i_rst) i_fetch_vld != 2'b10
  );

endmodule
